// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// data_mem_responder: word-addressed 32-bit data RAM behind the core's MemRead/MemWrite port.
// Latency: request seen in cycle T acks in cycle T+LATENCY+1; busy is high for LATENCY+1 cycles.
// Backpressure: combinational busy stalls the core until the ack cycle.
// Optional feature: define MISALIGN_CHECK_EN to flag Address[1:0]!=0 as a faulting access (err with ack).
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        busy,
  output logic        ack,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic                r_fault;
  logic                r_err;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

  logic                w_req;
  logic                w_fault_in;
  logic                w_access;
  logic                w_do_write;
  logic                w_unused_addr;

  assign w_req = MemRead | MemWrite;

  // Only the word-index bits (and, with the check enabled, the low two) matter.
  assign w_unused_addr = ^Address;

`ifdef MISALIGN_CHECK_EN
  assign w_fault_in = |Address[1:0];
  assign err        = r_err;
`else
  logic w_unused_err;
  assign w_fault_in   = 1'b0;
  assign err          = 1'b0;
  assign w_unused_err = r_err;
`endif

  // Access happens on the last WAIT cycle; a same-cycle reset aborts the write.
  assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_do_write = w_access && r_op_wr && !r_fault && !rst;

  // Stall in the very cycle a request appears, and throughout WAIT; released on ack.
  assign busy = ((r_state == S_IDLE) && w_req) || (r_state == S_WAIT);

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Request FSM: latch the request, count down the latency, then complete with a one-cycle ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_op_wr  <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= 32'd0;
      r_fault  <= 1'b0;
      r_err    <= 1'b0;
      ReadData <= 32'd0;
      ack      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ack   <= 1'b0;
          r_err <= 1'b0;
          if (w_req) begin
            // Write wins when both strobes are high.
            r_op_wr <= MemWrite;
            r_idx   <= Address[ADDR_W+1:2];
            r_wdata <= WriteData;
            r_fault <= w_fault_in;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Writes and faulting accesses return zero; reads return the addressed word.
            if (r_op_wr || r_fault) begin
              ReadData <= 32'd0;
            end else begin
              ReadData <= r_mem[r_idx];
            end
            ack     <= 1'b1;
            r_err   <= r_fault;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          ack     <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// tb_data_mem_responder: directed vector table, reset-abort sequence and randomized traffic
// checked against an array-based memory model and the documented ack latency.
module tb_data_mem_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        busy;
  logic        ack;
  logic        err;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .busy      (busy),
    .ack       (ack),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  // Issue one request (caller sits just after a negedge) and follow it to its ack.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit scramble,
                           output int lat, output int bcnt, output logic busy_at_ack,
                           output logic [31:0] rdat, output logic e);
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = wdata;
    #1;
    lat  = 0;
    bcnt = 0;
    while (ack !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
      if (scramble && ack !== 1'b1) begin
        MemRead   = 1'($urandom);
        MemWrite  = 1'($urandom);
        Address   = $urandom;
        WriteData = $urandom;
      end
      #1;
    end
    busy_at_ack = busy;
    rdat        = ReadData;
    e           = err;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
  endtask

  task automatic run_chk(input string nm, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit check_rd, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit scramble);
    int lat, bcnt;
    logic bat, e;
    logic [31:0] rdat;
    do_access(rd, wr, addr, wdata, scramble, lat, bcnt, bat, rdat, e);
    chk({nm, " ack latency"}, 32'(lat), 32'(LAT + 1));
    chk({nm, " busy cycles"}, 32'(bcnt), 32'(LAT + 1));
    chk({nm, " busy on ack"}, {31'd0, bat}, 32'd0);
    if (check_rd) chk({nm, " ReadData"}, rdat, exp_rdata);
    chk({nm, " err"}, {31'd0, e}, {31'd0, exp_err});
    @(negedge clk);
    #1;
    chk({nm, " ack pulse width"}, {31'd0, ack}, 32'd0);
  endtask

  logic [31:0] mem_m [0:(1<<ADDR_W)-1];
  bit          known [0:(1<<ADDR_W)-1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   seen_ack;
    rst       = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = 32'd0;
    WriteData = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle behaviour.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("idle ReadData", ReadData, 32'd0);
      chk("idle busy", {31'd0, busy}, 32'd0);
      chk("idle ack", {31'd0, ack}, 32'd0);
      chk("idle err", {31'd0, err}, 32'd0);
    end

    // Directed table, issued back to back.
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0042, 32'h1111_1111, 32'h0000_0000, MIS};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, (MIS ? 32'h0 : 32'h1111_1111), 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_chk($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              1'b1, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
    end

    // Reset during the second WAIT cycle aborts a write.
    run_chk("preload 0x40", 1'b0, 1'b1, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    MemWrite  = 1'b1;
    Address   = 32'h40;
    WriteData = 32'h7777_7777;
    seen_ack  = 1'b0;
    @(negedge clk);
    #1;
    if (ack === 1'b1) seen_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (ack === 1'b1) seen_ack = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    repeat (4) begin
      #1;
      if (ack === 1'b1) seen_ack = 1'b1;
      @(negedge clk);
    end
    chk("abort no ack", {31'd0, seen_ack}, 32'd0);
    chk("abort ReadData reset", ReadData, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    run_chk("read after abort", 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

    // Randomized traffic against an array model of the RAM.
    for (int i = 0; i < (1 << ADDR_W); i++) known[i] = 1'b0;
    for (int t = 0; t < 150; t++) begin
      logic [ADDR_W-1:0] idx;
      logic [31:0]       a, wd, exp_rd;
      logic              rd, wr, fault;
      bit                check_rd;
      int                op, gap;
      idx = ADDR_W'($urandom_range(0, 15));
      a   = $urandom;
      a[ADDR_W+1:2] = idx;
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wd  = $urandom;
      op  = $urandom_range(0, 2);
      rd  = (op != 1);
      wr  = (op != 0);
      fault = MIS && (a[1:0] != 2'b00);
      check_rd = 1'b1;
      exp_rd   = 32'd0;
      if (wr) begin
        if (!fault) begin
          mem_m[idx] = wd;
          known[idx] = 1'b1;
        end
      end else if (!fault) begin
        if (known[idx]) exp_rd = mem_m[idx];
        else check_rd = 1'b0;
      end
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      if (gap != 0) #1;
      run_chk($sformatf("rand%0d", t), rd, wr, a, wd, check_rd, exp_rd, fault,
              bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
